alu_operand_stage: RTL and testbench

- ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the ALU.
- Latches decoded operands and control from ID and resolves EX/MEM and MEM/WB forwarding.
- Drives the ALU's portA, portB and ALUOP.
- Detects load-use hazards, requests an ID stall and inserts a bubble into EX.

---
 rtl/alu_operand_stage.sv | 148 ++++++++++++++
 tb/tb_alu_operand_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register feeding the ALU: latches decoded operands/control,
// resolves EX/MEM and MEM/WB forwarding, and detects load-use hazards.
package alu_operand_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;
endpackage

module alu_operand_stage
    import alu_operand_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush,
    input  logic              id_valid,
    input  aluop_t            id_aluop,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_rt_used,
    input  logic [WORD_W-1:0] id_rdat1,
    input  logic [WORD_W-1:0] id_rdat2,
    input  logic [WORD_W-1:0] id_imm,
    input  logic              id_alusrc,
    input  logic              id_dmemren,
    input  logic              id_dmemwen,
    input  logic              id_regwen,
    input  logic [REG_W-1:0]  id_wsel,
    input  logic              mem_regwen,
    input  logic [REG_W-1:0]  mem_wsel,
    input  logic [WORD_W-1:0] mem_result,
    input  logic              wb_regwen,
    input  logic [REG_W-1:0]  wb_wsel,
    input  logic [WORD_W-1:0] wb_result,
    output logic [WORD_W-1:0] portA,
    output logic [WORD_W-1:0] portB,
    output aluop_t            ALUOP,
    output logic              ex_valid,
    output logic              ex_dmemren,
    output logic              ex_dmemwen,
    output logic              ex_regwen,
    output logic [REG_W-1:0]  ex_wsel,
    output logic [WORD_W-1:0] ex_storedata,
    output logic              stall
);

    logic              ex_valid_reg;
    aluop_t            ex_aluop_reg;
    logic [REG_W-1:0]  ex_rs_reg;
    logic [REG_W-1:0]  ex_rt_reg;
    logic [WORD_W-1:0] ex_rdat1_reg;
    logic [WORD_W-1:0] ex_rdat2_reg;
    logic [WORD_W-1:0] ex_imm_reg;
    logic              ex_alusrc_reg;
    logic              ex_dmemren_reg;
    logic              ex_dmemwen_reg;
    logic              ex_regwen_reg;
    logic [REG_W-1:0]  ex_wsel_reg;

    // A load in EX cannot forward its data until MEM, so a dependent ID
    // instruction must wait one cycle.
    assign stall = ex_valid_reg && ex_dmemren_reg && ex_regwen_reg
                && (ex_wsel_reg != '0) && id_valid
                && ((ex_wsel_reg == id_rs) || (id_rt_used && (ex_wsel_reg == id_rt)));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_valid_reg   <= 1'b0;
            ex_aluop_reg   <= ALU_SLL;
            ex_rs_reg      <= '0;
            ex_rt_reg      <= '0;
            ex_rdat1_reg   <= '0;
            ex_rdat2_reg   <= '0;
            ex_imm_reg     <= '0;
            ex_alusrc_reg  <= 1'b0;
            ex_dmemren_reg <= 1'b0;
            ex_dmemwen_reg <= 1'b0;
            ex_regwen_reg  <= 1'b0;
            ex_wsel_reg    <= '0;
        end else if (flush || (en && stall)) begin
            // Squash and bubble share the same effect on EX control.
            ex_valid_reg   <= 1'b0;
            ex_dmemren_reg <= 1'b0;
            ex_dmemwen_reg <= 1'b0;
            ex_regwen_reg  <= 1'b0;
        end else if (en) begin
            ex_valid_reg   <= id_valid;
            ex_aluop_reg   <= id_aluop;
            ex_rs_reg      <= id_rs;
            ex_rt_reg      <= id_rt;
            ex_rdat1_reg   <= id_rdat1;
            ex_rdat2_reg   <= id_rdat2;
            ex_imm_reg     <= id_imm;
            ex_alusrc_reg  <= id_alusrc;
            ex_dmemren_reg <= id_valid && id_dmemren;
            ex_dmemwen_reg <= id_valid && id_dmemwen;
            ex_regwen_reg  <= id_valid && id_regwen;
            ex_wsel_reg    <= id_wsel;
        end
    end

    logic [REG_W-1:0]  fwd_idx  [2];
    logic [WORD_W-1:0] fwd_base [2];
    logic [WORD_W-1:0] fwd_val  [2];

    assign fwd_idx[0]  = ex_rs_reg;
    assign fwd_idx[1]  = ex_rt_reg;
    assign fwd_base[0] = ex_rdat1_reg;
    assign fwd_base[1] = ex_rdat2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic mem_hit;
            logic wb_hit;
            assign mem_hit = mem_regwen && (mem_wsel != '0) && (mem_wsel == fwd_idx[gi]);
            assign wb_hit  = wb_regwen && (wb_wsel != '0) && (wb_wsel == fwd_idx[gi]);
            // The younger producer in MEM overrides the older one in WB.
            assign fwd_val[gi] = mem_hit ? mem_result :
                                 wb_hit  ? wb_result  : fwd_base[gi];
        end
    endgenerate

    assign portA        = fwd_val[0];
    assign portB        = ex_alusrc_reg ? ex_imm_reg : fwd_val[1];
    assign ex_storedata = fwd_val[1];
    assign ALUOP        = ex_aluop_reg;
    assign ex_valid     = ex_valid_reg;
    assign ex_dmemren   = ex_dmemren_reg;
    assign ex_dmemwen   = ex_dmemwen_reg;
    assign ex_regwen    = ex_regwen_reg;
    assign ex_wsel      = ex_wsel_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: scoreboarded ID->EX transfers plus
// directed forwarding, hazard, hold/flush and reset checks.
module tb_alu_operand_stage;
    import alu_operand_pkg::*;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    logic              CLK;
    logic              nRST;
    logic              en;
    logic              flush;
    logic              id_valid;
    aluop_t            id_aluop;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic              id_rt_used;
    logic [WORD_W-1:0] id_rdat1;
    logic [WORD_W-1:0] id_rdat2;
    logic [WORD_W-1:0] id_imm;
    logic              id_alusrc;
    logic              id_dmemren;
    logic              id_dmemwen;
    logic              id_regwen;
    logic [REG_W-1:0]  id_wsel;
    logic              mem_regwen;
    logic [REG_W-1:0]  mem_wsel;
    logic [WORD_W-1:0] mem_result;
    logic              wb_regwen;
    logic [REG_W-1:0]  wb_wsel;
    logic [WORD_W-1:0] wb_result;
    logic [WORD_W-1:0] portA;
    logic [WORD_W-1:0] portB;
    aluop_t            ALUOP;
    logic              ex_valid;
    logic              ex_dmemren;
    logic              ex_dmemwen;
    logic              ex_regwen;
    logic [REG_W-1:0]  ex_wsel;
    logic [WORD_W-1:0] ex_storedata;
    logic              stall;

    alu_operand_stage #(.WORD_W(WORD_W), .REG_W(REG_W)) dut (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
        .id_valid(id_valid), .id_aluop(id_aluop), .id_rs(id_rs), .id_rt(id_rt),
        .id_rt_used(id_rt_used), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2),
        .id_imm(id_imm), .id_alusrc(id_alusrc), .id_dmemren(id_dmemren),
        .id_dmemwen(id_dmemwen), .id_regwen(id_regwen), .id_wsel(id_wsel),
        .mem_regwen(mem_regwen), .mem_wsel(mem_wsel), .mem_result(mem_result),
        .wb_regwen(wb_regwen), .wb_wsel(wb_wsel), .wb_result(wb_result),
        .portA(portA), .portB(portB), .ALUOP(ALUOP), .ex_valid(ex_valid),
        .ex_dmemren(ex_dmemren), .ex_dmemwen(ex_dmemwen), .ex_regwen(ex_regwen),
        .ex_wsel(ex_wsel), .ex_storedata(ex_storedata), .stall(stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [3:0]  op;
        logic        ren;
        logic        wen;
        logic        regwen;
        logic [4:0]  wsel;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_txn = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive_id(input logic v, input aluop_t op, input logic [4:0] rs,
                            input logic [4:0] rt, input logic rt_used,
                            input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] imm, input logic alusrc,
                            input logic ren, input logic wen, input logic rw,
                            input logic [4:0] ws);
        id_valid = v;   id_aluop = op;   id_rs = rs;     id_rt = rt;
        id_rt_used = rt_used; id_rdat1 = r1; id_rdat2 = r2; id_imm = imm;
        id_alusrc = alusrc; id_dmemren = ren; id_dmemwen = wen;
        id_regwen = rw; id_wsel = ws;
    endtask

    // Expected EX view of the instruction, assuming no forwarding match.
    task automatic push_exp();
        exp_t e;
        e.valid  = id_valid;
        e.a      = id_rdat1;
        e.b      = id_alusrc ? id_imm : id_rdat2;
        e.sd     = id_rdat2;
        e.op     = id_aluop;
        e.ren    = id_valid & id_dmemren;
        e.wen    = id_valid & id_dmemwen;
        e.regwen = id_valid & id_regwen;
        e.wsel   = id_wsel;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
        chk("portA", portA, e.a);
        chk("portB", portB, e.b);
        chk("storedata", ex_storedata, e.sd);
        chk("ALUOP", {28'd0, ALUOP}, {28'd0, e.op});
        chk("ex_dmemren", {31'd0, ex_dmemren}, {31'd0, e.ren});
        chk("ex_dmemwen", {31'd0, ex_dmemwen}, {31'd0, e.wen});
        chk("ex_regwen", {31'd0, ex_regwen}, {31'd0, e.regwen});
        if (e.valid) chk("ex_wsel", {27'd0, ex_wsel}, {27'd0, e.wsel});
        n_txn++;
        $display("txn %0d: v=%0b A=%h B=%h sd=%h op=%0d (errors so far %0d)",
                 n_txn, ex_valid, portA, portB, ex_storedata, ALUOP, n_err);
    endtask

    task automatic issue(input logic v, input aluop_t op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic rt_used,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] imm, input logic alusrc,
                         input logic ren, input logic wen, input logic rw,
                         input logic [4:0] ws);
        @(negedge CLK);
        drive_id(v, op, rs, rt, rt_used, r1, r2, imm, alusrc, ren, wen, rw, ws);
        push_exp();
        @(posedge CLK);
        #1;
        pop_cmp();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        nRST = 1'b0; en = 1'b1; flush = 1'b0;
        mem_regwen = 1'b0; mem_wsel = '0; mem_result = '0;
        wb_regwen = 1'b0;  wb_wsel = '0;  wb_result = '0;
        drive_id(1'b1, ALU_ADD, 5'd1, 5'd2, 1'b1, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3);

        // Reset with live ID inputs across an edge
        @(posedge CLK); #1;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_aluop", {28'd0, ALUOP}, 32'd0);
        chk("rst_portA", portA, 32'd0);
        chk("rst_portB", portB, 32'd0);
        chk("rst_sd", ex_storedata, 32'd0);
        @(negedge CLK); nRST = 1'b1;

        // Basic add, then immediate operand
        issue(1'b1, ALU_ADD, 5'd1, 5'd2, 1'b1, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
        issue(1'b1, ALU_OR, 5'd1, 5'd2, 1'b0, 32'd1, 32'd9, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3);
        issue(1'b1, ALU_SW_DUMMY(), 5'd6, 5'd7, 1'b1, 32'h100, 32'hDEAD, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        // Invalid instruction latches with control forced low
        issue(1'b0, ALU_SUB, 5'd2, 5'd3, 1'b1, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9);

        // Forwarding, with EX held so the registered operands stay put
        issue(1'b1, ALU_ADD, 5'd3, 5'd4, 1'b1, 32'h33, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
        @(negedge CLK);
        en = 1'b0;
        mem_regwen = 1'b1; mem_wsel = 5'd3; mem_result = 32'h11;
        wb_regwen = 1'b1;  wb_wsel = 5'd3;  wb_result = 32'h22;
        #1 chk("fwd_mem_prio", portA, 32'h11);
        mem_regwen = 1'b0;
        #1 chk("fwd_wb", portA, 32'h22);
        wb_wsel = 5'd4;
        #1 chk("fwd_wb_rt_B", portB, 32'h22);
        chk("fwd_wb_rt_sd", ex_storedata, 32'h22);
        mem_regwen = 1'b1; mem_wsel = 5'd0; wb_wsel = 5'd0;
        #1 chk("fwd_r0_A", portA, 32'h33);
        chk("fwd_r0_B", portB, 32'h44);
        mem_regwen = 1'b0; wb_regwen = 1'b0;
        en = 1'b1;

        // Load-use: lw $8 in EX, dependent add in ID
        issue(1'b1, ALU_ADD, 5'd1, 5'd2, 1'b0, 32'h1000, 32'h0, 32'h4, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8);
        @(negedge CLK);
        drive_id(1'b1, ALU_ADD, 5'd8, 5'd9, 1'b1, 32'h0, 32'h99, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10);
        #1 chk("lu_stall", {31'd0, stall}, 32'd1);
        @(posedge CLK); #1;
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_rw", {31'd0, ex_regwen}, 32'd0);
        chk("lu_unstall", {31'd0, stall}, 32'd0);
        @(negedge CLK);
        mem_regwen = 1'b1; mem_wsel = 5'd8; mem_result = 32'hAB;
        @(posedge CLK); #1;
        chk("lu_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_fwd_A", portA, 32'hAB);
        chk("lu_B", portB, 32'h99);
        mem_regwen = 1'b0;

        // Hold for three cycles while ID changes
        issue(1'b1, ALU_XOR, 5'd11, 5'd12, 1'b1, 32'h55, 32'h66, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd13);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            en = 1'b0;
            drive_id(1'b1, ALU_AND, 5'($urandom_range(1, 31)), 5'd2, 1'b1, $urandom, $urandom,
                     $urandom, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1);
            @(posedge CLK); #1;
            chk("hold_valid", {31'd0, ex_valid}, 32'd1);
            chk("hold_A", portA, 32'h55);
            chk("hold_B", portB, 32'h66);
            chk("hold_op", {28'd0, ALUOP}, {28'd0, ALU_XOR});
        end
        @(negedge CLK);
        flush = 1'b1;
        @(posedge CLK); #1;
        chk("flush_noen", {31'd0, ex_valid}, 32'd0);
        @(negedge CLK); flush = 1'b0; en = 1'b1;

        // Flush coinciding with a load-use stall
        issue(1'b1, ALU_ADD, 5'd1, 5'd2, 1'b0, 32'h2000, 32'h0, 32'h8, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8);
        @(negedge CLK);
        drive_id(1'b1, ALU_ADD, 5'd8, 5'd3, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
        flush = 1'b1;
        #1 chk("flush_stall_comb", {31'd0, stall}, 32'd1);
        @(posedge CLK); #1;
        chk("flush_stall_valid", {31'd0, ex_valid}, 32'd0);
        @(negedge CLK); flush = 1'b0;

        // rt not used by the instruction: no stall; used: stall
        issue(1'b1, ALU_ADD, 5'd1, 5'd2, 1'b0, 32'h3000, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4);
        @(negedge CLK);
        en = 1'b0;
        drive_id(1'b1, ALU_ADD, 5'd1, 5'd4, 1'b0, 32'h0, 32'h0, 32'h1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4);
        #1 chk("rt_unused_stall", {31'd0, stall}, 32'd0);
        id_rt_used = 1'b1;
        #1 chk("rt_used_stall", {31'd0, stall}, 32'd1);
        id_valid = 1'b0;
        #1 chk("id_invalid_stall", {31'd0, stall}, 32'd0);
        en = 1'b1;

        // Load to $0 never causes a stall
        issue(1'b1, ALU_ADD, 5'd1, 5'd2, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0);
        @(negedge CLK);
        en = 1'b0;
        drive_id(1'b1, ALU_ADD, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1);
        #1 chk("r0_load_stall", {31'd0, stall}, 32'd0);
        en = 1'b1;

        // Asynchronous reset in the middle of a cycle
        issue(1'b1, ALU_SLT, 5'd5, 5'd6, 1'b1, 32'h77, 32'h88, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7);
        #2 nRST = 1'b0;
        #1 chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_A", portA, 32'd0);
        chk("arst_op", {28'd0, ALUOP}, 32'd0);
        @(negedge CLK); nRST = 1'b1;
        issue(1'b1, ALU_SUB, 5'd5, 5'd6, 1'b1, 32'h12, 32'h34, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7);

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    function automatic aluop_t ALU_SW_DUMMY();
        return ALU_ADD;
    endfunction

endmodule
